// File: rtl/lsu_bus_bridge_pkg.sv
// Shared types and helpers for the memory-stage load/store bridge.
// Keeps size decoding and alignment rules in one place for RTL and bench.
package lsu_bus_bridge_pkg;

  localparam int LSU_XLEN = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic                we;
    lsu_size_e           size;
    logic                is_unsigned;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] wdata;
  } type_lsu_req_s;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic lsu_size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] lane);
    case (size)
      HALF:    return lane[0];
      WORD:    return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_bridge_if.sv
// Bundle of pipeline request/response and slave-bus signals for the LSU bridge.
// slave modport: the bridge itself; master modport: pipeline plus slave fabric around it.
interface lsu_bus_bridge_if #(
  parameter int BUS_WIDTH    = 32,
  parameter int N_SLV        = 4,
  parameter int REGION_SHIFT = 12
);
  // Handshake: req_valid is held stable while stall=1; the bridge pulses
  // rsp_valid for exactly one cycle per accepted request. On the slave side
  // slv_sel stays asserted (with we/addr/wdata/be stable) until the selected
  // slave raises its slv_ack bit for one cycle; acks from other slaves are ignored.
  logic                      req_valid;
  logic                      req_we;
  logic [1:0]                req_size;
  logic                      req_unsigned;
  logic [BUS_WIDTH-1:0]      req_addr;
  logic [BUS_WIDTH-1:0]      req_wdata;
  logic                      stall;
  logic                      rsp_valid;
  logic [BUS_WIDTH-1:0]      rdata;
  logic                      exc_misalign;
  logic                      exc_fault;
  logic [BUS_WIDTH-1:0]      exc_addr;
  logic [N_SLV-1:0]          slv_sel;
  logic                      slv_we;
  logic [REGION_SHIFT-1:0]   slv_addr;
  logic [BUS_WIDTH-1:0]      slv_wdata;
  logic [BUS_WIDTH/8-1:0]    slv_be;
  logic [N_SLV-1:0]          slv_ack;
  logic [N_SLV*BUS_WIDTH-1:0] slv_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  slv_ack, slv_rdata,
    output stall, rsp_valid, rdata, exc_misalign, exc_fault, exc_addr,
    output slv_sel, slv_we, slv_addr, slv_wdata, slv_be
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output slv_ack, slv_rdata,
    input  stall, rsp_valid, rdata, exc_misalign, exc_fault, exc_addr,
    input  slv_sel, slv_we, slv_addr, slv_wdata, slv_be
  );
endinterface

// File: rtl/lsu_bus_bridge_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension,
// and store lane replication with byte-enable generation.
module lsu_align
  import lsu_bus_bridge_pkg::*;
(
  input  lsu_size_e   size,
  input  logic        is_unsigned,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] word_rdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data,
  output logic [3:0]  be
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'h00;
    case (lane)
      2'd0: byte_v = word_rdata[7:0];
      2'd1: byte_v = word_rdata[15:8];
      2'd2: byte_v = word_rdata[23:16];
      2'd3: byte_v = word_rdata[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = lane[1] ? word_rdata[31:16] : word_rdata[15:0];
  end

  always_comb begin
    load_data  = word_rdata;
    store_data = wdata;
    be         = 4'b1111;
    case (size)
      BYTE: begin
        load_data  = {{24{~is_unsigned & byte_v[7]}}, byte_v};
        store_data = {4{wdata[7:0]}};
        be         = 4'b0001 << lane;
      end
      HALF: begin
        load_data  = {{16{~is_unsigned & half_v[15]}}, half_v};
        store_data = {2{wdata[15:0]}};
        be         = 4'b0011 << lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_bridge.sv
// Memory-stage load/store bridge: decodes the address to one of N_SLV regions,
// runs a req/ack access with watchdog, and stalls the pipeline until it completes.
module lsu_bus_bridge
  import lsu_bus_bridge_pkg::*;
#(
  parameter int BUS_WIDTH    = 32,
  parameter int N_SLV        = 4,
  parameter int REGION_SHIFT = 12,
  parameter int TIMEOUT      = 15
) (
  input  logic             clk,
  input  logic             rst,
  lsu_bus_bridge_if.slave  bus,
  output lsu_state_e       dbg_state
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RW    = BUS_WIDTH - REGION_SHIFT;
  localparam logic [RW-1:0] N_SLV_R = RW'(N_SLV);

  lsu_state_e          state_q, state_d;
  type_lsu_req_s       req_q, req_live;
  logic [IDX_W-1:0]    idx_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [31:0]         rdata_q;
  logic                misalign_q, fault_q;

  logic [RW-1:0]       region;
  logic                live_misalign, live_fault;
  logic                ack_hit, timeout_hit;
  logic [31:0]         sel_rdata, load_data, store_data;
  logic [3:0]          be;
  logic                in_access, in_done;
  logic [N_SLV-1:0]    sel_vec;

  assign req_live.we          = bus.req_we;
  assign req_live.size        = decode_size(bus.req_size);
  assign req_live.is_unsigned = bus.req_unsigned;
  assign req_live.addr        = bus.req_addr;
  assign req_live.wdata       = bus.req_wdata;

  assign region        = bus.req_addr[BUS_WIDTH-1:REGION_SHIFT];
  assign live_misalign = is_misaligned(req_live.size, bus.req_addr[1:0]);
  assign live_fault    = region >= N_SLV_R;

  // Watchdog fires in the TIMEOUT-th ACCESS cycle; a same-cycle ack still wins.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    ack_hit   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ack_hit   = bus.slv_ack[i];
        sel_rdata = bus.slv_rdata[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  lsu_align u_align (
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .lane        (req_q.addr[1:0]),
    .wdata       (req_q.wdata),
    .word_rdata  (sel_rdata),
    .load_data   (load_data),
    .store_data  (store_data),
    .be          (be)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid)
          state_d = (live_misalign || live_fault) ? DONE : ACCESS;
      end
      ACCESS: begin
        if (ack_hit || timeout_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_q      <= req_live;
            idx_q      <= region[IDX_W-1:0];
            cnt_q      <= '0;
            rdata_q    <= '0;
            misalign_q <= live_misalign;
            fault_q    <= !live_misalign && live_fault;
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (ack_hit)          rdata_q <= req_q.we ? '0 : load_data;
          else if (timeout_hit) fault_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_done   = (state_q == DONE);

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < N_SLV; i++)
      sel_vec[i] = in_access && (idx_q == IDX_W'(i));
  end

  // Reset must silence stall at once even if the pipeline still holds req_valid.
  assign bus.stall        = rst && ((state_q == IDLE && bus.req_valid) || in_access);
  assign bus.rsp_valid    = in_done;
  assign bus.rdata        = in_done ? rdata_q : '0;
  assign bus.exc_misalign = in_done && misalign_q;
  assign bus.exc_fault    = in_done && fault_q;
  assign bus.exc_addr     = (in_done && (misalign_q || fault_q)) ? req_q.addr : '0;

  assign bus.slv_sel   = sel_vec;
  assign bus.slv_we    = in_access && req_q.we;
  assign bus.slv_addr  = in_access ? {req_q.addr[REGION_SHIFT-1:2], 2'b00} : '0;
  assign bus.slv_wdata = in_access ? store_data : '0;
  assign bus.slv_be    = in_access ? be : '0;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: loads/stores, extension, exceptions,
// watchdog boundary and asynchronous reset during an access.
module tb_lsu_bus_bridge;
  import lsu_bus_bridge_pkg::*;

  localparam int BW = 32;
  localparam int NS = 4;
  localparam int RS = 12;
  localparam int TO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lsu_bus_bridge_if #(.BUS_WIDTH(BW), .N_SLV(NS), .REGION_SHIFT(RS)) bus ();
  lsu_state_e dbg_state;

  lsu_bus_bridge #(.BUS_WIDTH(BW), .N_SLV(NS), .REGION_SHIFT(RS), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observations from the most recent access.
  int          o_rsp_cyc, o_stall_cnt;
  logic        o_mis, o_flt, o_we;
  logic [31:0] o_exc_addr, o_wdata;
  logic [3:0]  o_sel, o_sel_seen, o_be;
  logic [11:0] o_addr;

  // ---------------- driver ----------------
  // ack_after = number of wait states before the selected slave acks; -1 = never.
  // Cycles before the real ack carry a decoy ack from the neighbouring slave.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_after, input logic [31:0] slave_word,
                           input logic [31:0] exp_rdata);
    int acc_n = 0;
    int tgt;
    int decoy;
    bit seen = 0;
    logic [31:0] got_rd = '0;
    tgt   = int'(addr[13:12]);
    decoy = (tgt + 1) % NS;
    exp_q.push_back(exp_rdata);
    o_rsp_cyc = 0; o_stall_cnt = 0; o_mis = 0; o_flt = 0; o_we = 0;
    o_exc_addr = '0; o_wdata = '0; o_sel = '0; o_sel_seen = '0; o_be = '0; o_addr = '0;
    @(posedge clk); #1;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    for (int cyc = 1; cyc <= 40 && !seen; cyc++) begin
      @(negedge clk);
      if (bus.stall) o_stall_cnt++;
      if (bus.slv_sel != '0) begin
        acc_n++;
        o_sel      = bus.slv_sel;
        o_sel_seen = o_sel_seen | bus.slv_sel;
        o_be       = bus.slv_be;
        o_wdata    = bus.slv_wdata;
        o_we       = bus.slv_we;
        o_addr     = bus.slv_addr;
        if (ack_after >= 0 && acc_n == ack_after + 1) begin
          bus.slv_ack = 4'b0001 << tgt;
          bus.slv_rdata[tgt*32 +: 32] = slave_word;
        end else begin
          bus.slv_ack = 4'b0001 << decoy;
          bus.slv_rdata[decoy*32 +: 32] = ~slave_word;
        end
      end
      if (bus.rsp_valid) begin
        seen       = 1;
        o_rsp_cyc  = cyc;
        got_rd     = bus.rdata;
        o_mis      = bus.exc_misalign;
        o_flt      = bus.exc_fault;
        o_exc_addr = bus.exc_addr;
      end
      @(posedge clk); #1;
      bus.slv_ack   = '0;
      bus.slv_rdata = '0;
    end
    bus.req_valid = 1'b0;
    check("rsp_seen", 32'(seen), 32'd1);
    check("rdata", got_rd, exp_q.pop_front());
    @(negedge clk);
    check("rsp_single_pulse", 32'(bus.rsp_valid), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 2'b10; bus.req_unsigned = 0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.slv_ack = '0; bus.slv_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rdata", bus.rdata, 0);
    check("rst_slv_sel", 32'(bus.slv_sel), 0);
    check("rst_exc", {30'd0, bus.exc_misalign, bus.exc_fault}, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b1;

    // LW slave 1, two wait states
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_1008, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    check("lw_rsp_cyc", o_rsp_cyc, 5);
    check("lw_stall_cnt", o_stall_cnt, 4);
    check("lw_slv_addr", 32'(o_addr), 32'h008);
    check("lw_slv_sel", 32'(o_sel), 32'b0010);
    check("lw_slv_be", 32'(o_be), 32'hF);
    check("lw_no_exc", {30'd0, o_mis, o_flt}, 0);
    check("lw_exc_addr", o_exc_addr, 0);

    // Byte / half loads with sign and zero extension
    do_access(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 0, 32'h8012_3456, 32'hFFFF_FF80);
    check("lb_rsp_cyc", o_rsp_cyc, 3);
    do_access(1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 0, 32'h8012_3456, 32'h0000_0080);
    do_access(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 0, 32'h8001_7FFF, 32'hFFFF_8001);
    do_access(1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 1, 32'h8001_FFFF, 32'h0000_FFFF);
    do_access(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0, 1, 32'h0000_7F00, 32'h0000_007F);
    check("lb1_rsp_cyc", o_rsp_cyc, 4);

    // Stores: lane replication and byte enables
    do_access(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 1, 32'h5555_5555, 32'h0);
    check("sh_slv_sel", 32'(o_sel), 32'b0100);
    check("sh_slv_be", 32'(o_be), 32'b1100);
    check("sh_slv_wdata", o_wdata, 32'hABCD_ABCD);
    check("sh_slv_we", 32'(o_we), 1);
    check("sh_slv_addr", 32'(o_addr), 32'h000);
    do_access(1'b1, 2'b00, 1'b0, 32'h0000_3005, 32'h0000_0055, 0, 32'h0, 32'h0);
    check("sb_slv_sel", 32'(o_sel), 32'b1000);
    check("sb_slv_be", 32'(o_be), 32'b0010);
    check("sb_slv_wdata", o_wdata, 32'h5555_5555);
    check("sb_slv_addr", 32'(o_addr), 32'h004);
    do_access(1'b1, 2'b11, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 0, 32'h0, 32'h0);
    check("sw11_slv_sel", 32'(o_sel), 32'b0001);
    check("sw11_slv_be", 32'(o_be), 32'hF);
    check("sw11_slv_wdata", o_wdata, 32'hCAFE_F00D);
    check("sw11_slv_addr", 32'(o_addr), 32'hFFC);

    // Exceptions
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 0, 32'h1111_1111, 32'h0);
    check("mis_flags", {30'd0, o_mis, o_flt}, 32'b10);
    check("mis_exc_addr", o_exc_addr, 32'h6);
    check("mis_no_sel", 32'(o_sel_seen), 0);
    check("mis_rsp_cyc", o_rsp_cyc, 2);
    check("mis_stall_cnt", o_stall_cnt, 1);
    do_access(1'b0, 2'b01, 1'b0, 32'h0000_1001, 32'h0, 0, 32'h0, 32'h0);
    check("mis_lh_flags", {30'd0, o_mis, o_flt}, 32'b10);
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 0, 32'h0, 32'h0);
    check("flt_flags", {30'd0, o_mis, o_flt}, 32'b01);
    check("flt_exc_addr", o_exc_addr, 32'h5000);
    check("flt_rsp_cyc", o_rsp_cyc, 2);
    check("flt_no_sel", 32'(o_sel_seen), 0);
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_5002, 32'h0, 0, 32'h0, 32'h0);
    check("mis_over_flt", {30'd0, o_mis, o_flt}, 32'b10);
    do_access(1'b1, 2'b00, 1'b0, 32'h0000_4003, 32'hFF, 0, 32'h0, 32'h0);
    check("sb_flt_flags", {30'd0, o_mis, o_flt}, 32'b01);

    // Watchdog: no ack, then ack on the last allowed cycle
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, -1, 32'h2222_2222, 32'h0);
    check("to_flags", {30'd0, o_mis, o_flt}, 32'b01);
    check("to_rsp_cyc", o_rsp_cyc, TO + 2);
    check("to_stall_cnt", o_stall_cnt, TO + 1);
    check("to_exc_addr", o_exc_addr, 32'h1000);
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_1004, 32'h0, TO - 1, 32'h3333_4444, 32'h3333_4444);
    check("to_edge_flags", {30'd0, o_mis, o_flt}, 0);
    check("to_edge_rsp_cyc", o_rsp_cyc, TO + 2);

    // Asynchronous reset during ACCESS
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_addr = 32'h0000_2010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_sel", 32'(bus.slv_sel), 32'b0100);
    rst = 1'b0;
    #1;
    check("mid_rst_stall", 32'(bus.stall), 0);
    check("mid_rst_sel", 32'(bus.slv_sel), 0);
    check("mid_rst_be", 32'(bus.slv_be), 0);
    check("mid_rst_rsp", 32'(bus.rsp_valid), 0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_rsp", 32'(bus.rsp_valid), 0);
    rst = 1'b1;
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_2010, 32'h0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D);
    check("post_rst_rsp_cyc", o_rsp_cyc, 3);
    check("post_rst_sel", 32'(o_sel), 32'b0100);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
